alu_res_station: RTL and testbench

Reservation station for the integer ALU/compare functional unit, directly downstream of the dispatch stage. It holds up to `RS_DEPTH` dispatched `dis_ex_t` entries whose `rs_type` selects the ALU station, and snoops the two CDBs to capture missing source operands. It issues one fully ready entry per cycle to the ALU and drives `add_full` back to dispatch.

---
 rtl/alu_res_station.sv | 149 ++++++++++++++
 tb/tb_alu_res_station.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_res_station.sv
// alu_res_station: reservation station for the integer ALU/compare unit.
// Holds dispatched entries, snoops both CDBs for missing operands and issues
// the lowest-index ready entry. Optional same-cycle wakeup-to-issue bypass
// is enabled by defining RS_WAKEUP_BYPASS_EN.

package alu_rs_pkg;
  localparam int unsigned ROB_DEPTH_DEF = 32;
  localparam int unsigned TAG_W         = $clog2(ROB_DEPTH_DEF);

  typedef struct packed {
    logic             rs1_rdy;
    logic             rs2_rdy;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [TAG_W-1:0] Qj;
    logic [TAG_W-1:0] Qk;
    logic [3:0]       aluop;
    logic             cmp;
    logic [TAG_W-1:0] rob_num;
    logic [4:0]       rd;
    logic [31:0]      pc;
    logic [7:0]       order;
  } dis_ex_t;
endpackage

module alu_res_station
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_DEPTH  = 8,
  parameter int unsigned ROB_DEPTH = alu_rs_pkg::ROB_DEPTH_DEF,
  parameter int          TAG_LEN   = $clog2(ROB_DEPTH) - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   dis_valid,
  input  dis_ex_t                dis_entry,
  input  logic [1:0]             cdb_valid,
  input  logic [1:0][TAG_LEN:0]  cdb_tag,
  input  logic [1:0][31:0]       cdb_result,
  output logic                   add_full,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output dis_ex_t                issue_entry
);

  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] valid_q;
  logic [RS_DEPTH-1:0] valid_d;
  dis_ex_t             ent_q [RS_DEPTH];
  dis_ex_t             ent_d [RS_DEPTH];
  dis_ex_t             woken [RS_DEPTH];
  logic [RS_DEPTH-1:0] cand;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    alloc_idx;
  logic                sel_found;
  logic                free_found;

  // Apply both CDBs to the not-ready operands of an entry; bus 0 applied last so it wins.
  function automatic dis_ex_t wake(input dis_ex_t e,
                                   input logic [1:0] v,
                                   input logic [1:0][TAG_LEN:0] t,
                                   input logic [1:0][31:0] r);
    dis_ex_t o;
    o = e;
    for (int b = 1; b >= 0; b--) begin
      if (!e.rs1_rdy && v[b] && (TAG_W'(t[b]) == e.Qj)) begin
        o.rs1_rdy  = 1'b1;
        o.rs1_data = r[b];
      end
      if (!e.rs2_rdy && v[b] && (TAG_W'(t[b]) == e.Qk)) begin
        o.rs2_rdy  = 1'b1;
        o.rs2_data = r[b];
      end
    end
    return o;
  endfunction

  // Wakeup, selection, allocation and next-state computation.
  always_comb begin
    add_full    = &valid_q;
    sel_found   = 1'b0;
    sel_idx     = '0;
    free_found  = 1'b0;
    alloc_idx   = '0;
    issue_entry = '0;
    valid_d     = valid_q;

    for (int i = 0; i < RS_DEPTH; i++) begin
      woken[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_result);
`ifdef RS_WAKEUP_BYPASS_EN
      cand[i]  = valid_q[i] & woken[i].rs1_rdy & woken[i].rs2_rdy;
`else
      cand[i]  = valid_q[i] & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
`endif
      ent_d[i] = valid_q[i] ? woken[i] : ent_q[i];
    end

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cand[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end

    issue_valid = sel_found;
    if (sel_found) begin
`ifdef RS_WAKEUP_BYPASS_EN
      issue_entry = woken[sel_idx];
`else
      issue_entry = ent_q[sel_idx];
`endif
    end

    if (issue_valid && issue_ready) begin
      valid_d[sel_idx] = 1'b0;
    end

    // Free slot comes from registered state, so an issuing slot is never the target.
    if (dis_valid && !add_full && free_found) begin
      valid_d[alloc_idx] = 1'b1;
      ent_d[alloc_idx]   = wake(dis_entry, cdb_valid, cdb_tag, cdb_result);
    end
  end

  // Occupancy register: reset, then flush, then normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; contents are don't-care while the entry is invalid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_alu_res_station.sv
// Directed self-checking bench for alu_res_station (default or RS_WAKEUP_BYPASS_EN build).
module tb_alu_res_station;
  import alu_rs_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             dis_valid;
  dis_ex_t          dis_entry;
  logic [1:0]       cdb_valid;
  logic [1:0][4:0]  cdb_tag;
  logic [1:0][31:0] cdb_result;
  logic             add_full;
  logic             issue_valid;
  logic             issue_ready;
  dis_ex_t          issue_entry;

  int npass = 0;
  int nchk  = 0;

  alu_res_station dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .dis_valid   (dis_valid),
    .dis_entry   (dis_entry),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_result  (cdb_result),
    .add_full    (add_full),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_entry (issue_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic dis_ex_t mk(input int rob, input logic r1, input logic [31:0] d1,
                                 input int qj, input logic r2, input logic [31:0] d2,
                                 input int qk);
    dis_ex_t e;
    e          = '0;
    e.rob_num  = 5'(rob);
    e.rs1_rdy  = r1;
    e.rs1_data = d1;
    e.Qj       = 5'(qj);
    e.rs2_rdy  = r2;
    e.rs2_data = d2;
    e.Qk       = 5'(qk);
    e.aluop    = 4'd1;
    e.rd       = 5'(rob);
    e.pc       = 32'h1000 + 32'(rob * 4);
    return e;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; dis_valid = 1'b0; dis_entry = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_result = '0; issue_ready = 1'b0;

    // reset then idle
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("idle_issue_valid", 64'(issue_valid), 64'd0);
      check("idle_add_full", 64'(add_full), 64'd0);
      check("idle_entry_zero", 64'(issue_entry == '0), 64'd1);
      cyc();
    end

    // ready ADD issues the next cycle
    dis_valid = 1'b1; dis_entry = mk(3, 1'b1, 32'd5, 0, 1'b1, 32'd7, 0); issue_ready = 1'b1;
    #1 check("add_no_same_cycle", 64'(issue_valid), 64'd0);
    cyc(); dis_valid = 1'b0;
    #1;
    check("add_issue_valid", 64'(issue_valid), 64'd1);
    check("add_rob", 64'(issue_entry.rob_num), 64'd3);
    check("add_rs1", 64'(issue_entry.rs1_data), 64'd5);
    check("add_rs2", 64'(issue_entry.rs2_data), 64'd7);
    cyc();
    #1 check("add_gone", 64'(issue_valid), 64'd0);

    // wakeup via bus 1
    cyc(); issue_ready = 1'b0; dis_valid = 1'b1; dis_entry = mk(10, 1'b0, 32'd0, 9, 1'b1, 32'd2, 0);
    cyc(); dis_valid = 1'b0;
    #1 check("wait_not_ready", 64'(issue_valid), 64'd0);
    cyc(); cdb_valid = 2'b10; cdb_tag[1] = 5'd9; cdb_result[1] = 32'h1234;
    #1;
`ifdef RS_WAKEUP_BYPASS_EN
    check("bypass_valid", 64'(issue_valid), 64'd1);
    check("bypass_rs1", 64'(issue_entry.rs1_data), 64'h1234);
    check("bypass_rdy", 64'(issue_entry.rs1_rdy), 64'd1);
`else
    check("nobypass_valid", 64'(issue_valid), 64'd0);
`endif
    cyc(); cdb_valid = 2'b00;
    #1;
    check("wake_valid", 64'(issue_valid), 64'd1);
    check("wake_rob", 64'(issue_entry.rob_num), 64'd10);
    check("wake_rs1", 64'(issue_entry.rs1_data), 64'h1234);
    check("wake_rs1_rdy", 64'(issue_entry.rs1_rdy), 64'd1);
    issue_ready = 1'b1;
    cyc();
    #1 check("wake_gone", 64'(issue_valid), 64'd0);

    // fill all entries waiting on tag 4
    cyc(); issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dis_valid = 1'b1; dis_entry = mk(i, 1'b0, 32'd0, 4, 1'b1, 32'(100 + i), 0);
      #1 check("fill_not_full", 64'(add_full), 64'd0);
      cyc();
    end
    dis_valid = 1'b1; dis_entry = mk(15, 1'b1, 32'd1, 0, 1'b1, 32'd1, 0);
    #1;
    check("full_flag", 64'(add_full), 64'd1);
    check("full_none_ready", 64'(issue_valid), 64'd0);
    cyc(); dis_valid = 1'b0; cdb_valid = 2'b01; cdb_tag[0] = 5'd4; cdb_result[0] = 32'hAA;
    #1;
    check("bcast_full", 64'(add_full), 64'd1);
`ifdef RS_WAKEUP_BYPASS_EN
    check("bcast_bypass_valid", 64'(issue_valid), 64'd1);
`else
    check("bcast_nobypass_valid", 64'(issue_valid), 64'd0);
`endif
    cyc(); cdb_valid = 2'b00; issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_valid", 64'(issue_valid), 64'd1);
      check("drain_rob", 64'(issue_entry.rob_num), 64'(i));
      check("drain_rs1", 64'(issue_entry.rs1_data), 64'hAA);
      check("drain_rs2", 64'(issue_entry.rs2_data), 64'(100 + i));
      if (i == 0) check("drain_full_held", 64'(add_full), 64'd1);
      if (i == 1) check("drain_full_drop", 64'(add_full), 64'd0);
      cyc();
    end
    #1 check("ninth_dropped", 64'(issue_valid), 64'd0);

    // capture on write, both buses match, bus 0 wins
    dis_valid = 1'b1; dis_entry = mk(12, 1'b1, 32'h11, 0, 1'b0, 32'd0, 6);
    cdb_valid = 2'b11; cdb_tag[0] = 5'd6; cdb_result[0] = 32'h66;
    cdb_tag[1] = 5'd6; cdb_result[1] = 32'h77;
    #1 check("cow_not_same_cycle", 64'(issue_valid), 64'd0);
    cyc(); dis_valid = 1'b0; cdb_valid = 2'b00;
    #1;
    check("cow_valid", 64'(issue_valid), 64'd1);
    check("cow_rob", 64'(issue_entry.rob_num), 64'd12);
    check("cow_rs2_bus0", 64'(issue_entry.rs2_data), 64'h66);
    check("cow_rs2_rdy", 64'(issue_entry.rs2_rdy), 64'd1);
    check("cow_rs1", 64'(issue_entry.rs1_data), 64'h11);
    cyc();
    #1 check("cow_gone", 64'(issue_valid), 64'd0);

    // flush with dispatch and handshake in the same cycle
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dis_valid = 1'b1; dis_entry = mk(20 + k, 1'b1, 32'(k), 0, 1'b1, 32'(k), 0);
      cyc();
    end
    dis_entry = mk(23, 1'b1, 32'd9, 0, 1'b1, 32'd9, 0); flush = 1'b1; issue_ready = 1'b1;
    #1;
    check("pre_flush_valid", 64'(issue_valid), 64'd1);
    check("pre_flush_rob", 64'(issue_entry.rob_num), 64'd20);
    cyc(); flush = 1'b0; dis_valid = 1'b0;
    #1;
    check("flush_valid", 64'(issue_valid), 64'd0);
    check("flush_full", 64'(add_full), 64'd0);
    cyc();
    #1;
    check("flush_still_empty", 64'(issue_valid), 64'd0);
    check("flush_entry_zero", 64'(issue_entry == '0), 64'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
